// File: rtl/des_cb_pkg.sv
// des_cb_pkg
// Shared definitions for the DES key-search datapath: the default key and
// block widths and the state encoding of the trial sequencer.
package des_cb_pkg;

    localparam int KEY_W = 56;  // DES key width
    localparam int BLK_W = 64;  // plaintext / ciphertext block width

    // IDLE  : waiting for the controller to launch a trial
    // REQ   : trial handed to the DES engine, waiting for des_ack
    // DONE  : compare result held in match_r, waiting for en1
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/key_counter.sv
// key_counter
// Key under trial. Loads start_key or steps by one (wrapping modulo
// 2^KEY_W) and flags when the current key equals end_key.
// Ports:
//   clk, reset       clock, synchronous active-low reset (count -> 0)
//   load             count <= start_key (takes priority over inc)
//   inc              count <= count + 1
//   start_key        first key of the search range
//   end_key          last key of the search range (inclusive)
//   count            current key
//   at_end           count == end_key
module key_counter #(
    parameter int KEY_W = des_cb_pkg::KEY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             inc,
    input  logic [KEY_W-1:0] start_key,
    input  logic [KEY_W-1:0] end_key,
    output logic [KEY_W-1:0] count,
    output logic             at_end
);

    always_ff @(posedge clk) begin
        if (!reset)
            count <= '0;
        else if (load)
            count <= start_key;
        else if (inc)
            count <= count + 1'b1;  // natural wrap from all-ones to 0
    end

    assign at_end = (count == end_key);

endmodule

// File: rtl/key_search_dp.sv
// key_search_dp
// Datapath of a brute-force DES key search. Each up pulse launches one
// trial on an external DES engine with the next key; the returned
// ciphertext is compared with target_ct, en1 commits the result to
// found/exhausted, and en2 captures the winning key.
// Ports:
//   clk, reset           clock, synchronous active-low reset
//   up, en1, en2         controller strobes: launch trial / commit / capture
//   start_key, end_key   inclusive key range (may wrap through 0)
//   target_ct            expected ciphertext
//   des_req, des_key     request and key to the DES engine
//   des_ack, des_ct      DES engine completion strobe and ciphertext
//   busy                 trial in flight
//   found, exhausted     sticky search result flags
//   key_out, key_valid   captured matching key
module key_search_dp #(
    parameter int KEY_W = des_cb_pkg::KEY_W,
    parameter int BLK_W = des_cb_pkg::BLK_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             up,
    input  logic             en1,
    input  logic             en2,
    input  logic [KEY_W-1:0] start_key,
    input  logic [KEY_W-1:0] end_key,
    input  logic [BLK_W-1:0] target_ct,
    output logic             des_req,
    output logic [KEY_W-1:0] des_key,
    input  logic             des_ack,
    input  logic [BLK_W-1:0] des_ct,
    output logic             busy,
    output logic             found,
    output logic             exhausted,
    output logic [KEY_W-1:0] key_out,
    output logic             key_valid
);

    import des_cb_pkg::*;

    state_t           state, state_nxt;
    logic             first;      // next launch loads start_key instead of stepping
    logic             match_r;    // compare result of the last completed trial
    logic             cnt_load, cnt_inc, capture, commit;
    logic [KEY_W-1:0] count;
    logic             at_end;

    key_counter #(.KEY_W(KEY_W)) u_key_counter (
        .clk       (clk),
        .reset     (reset),
        .load      (cnt_load),
        .inc       (cnt_inc),
        .start_key (start_key),
        .end_key   (end_key),
        .count     (count),
        .at_end    (at_end)
    );

    always_ff @(posedge clk) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                // Once the search has a result, further launches are refused.
                if (up && !exhausted && !found) begin
                    cnt_load  = first;
                    cnt_inc   = !first;
                    state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (des_ack) begin
                    capture   = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                // up arriving with en1 is dropped: only the commit happens.
                if (en1) begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            first     <= 1'b1;
            match_r   <= 1'b0;
            found     <= 1'b0;
            exhausted <= 1'b0;
            key_out   <= '0;
            key_valid <= 1'b0;
        end else begin
            if (cnt_load)
                first <= 1'b0;
            if (capture)
                match_r <= (des_ct == target_ct);
            if (commit) begin
                found     <= found | match_r;
                exhausted <= exhausted | (!match_r && at_end);
            end
            // The counter is not advanced after a match, so it still holds
            // the matching key whenever found is set.
            if (en2 && found) begin
                key_out   <= count;
                key_valid <= 1'b1;
            end
        end
    end

    assign des_req = (state == ST_REQ);
    assign busy    = (state == ST_REQ);
    assign des_key = count;

endmodule

// File: tb/tb_key_search_dp.sv
module tb_key_search_dp;

    localparam int KW = 56;
    localparam int BW = 64;
    localparam logic [BW-1:0] TGT = 64'h0123_4567_89AB_CDEF;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          up = 1'b0, en1 = 1'b0, en2 = 1'b0;
    logic [KW-1:0] start_key = '0, end_key = '0;
    logic [BW-1:0] target_ct = TGT;
    logic          des_req;
    logic [KW-1:0] des_key;
    logic          des_ack = 1'b0;
    logic [BW-1:0] des_ct = '0;
    logic          busy, found, exhausted, key_valid;
    logic [KW-1:0] key_out;

    logic [KW-1:0] match_key;   // the one key the DES model "accepts"
    int checks = 0;
    int errors = 0;

    key_search_dp #(.KEY_W(KW), .BLK_W(BW)) dut (
        .clk(clk), .reset(reset), .up(up), .en1(en1), .en2(en2),
        .start_key(start_key), .end_key(end_key), .target_ct(target_ct),
        .des_req(des_req), .des_key(des_key), .des_ack(des_ack), .des_ct(des_ct),
        .busy(busy), .found(found), .exhausted(exhausted),
        .key_out(key_out), .key_valid(key_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        @(negedge clk); reset = 1'b1;
    endtask

    task automatic pulse_up_refused(input string tag);
        @(negedge clk); up = 1'b1;
        @(negedge clk); up = 1'b0;
        chk(tag, {63'd0, des_req}, 64'd0);
    endtask

    // One full trial: launch, hold REQ for dly cycles, ack, commit.
    task automatic trial(input logic [KW-1:0] k, input int dly, input bit up_in_req,
                         input bit up_with_en1, input bit ef, input bit ex);
        @(negedge clk); up = 1'b1;
        @(negedge clk); up = 1'b0;
        chk("req_up",   {63'd0, des_req}, 64'd1);
        chk("busy_req", {63'd0, busy},    64'd1);
        chk("des_key",  {8'd0, des_key},  {8'd0, k});
        for (int i = 0; i < dly; i++) begin
            if (up_in_req && i == 0) up = 1'b1;
            @(negedge clk); up = 1'b0;
            chk("req_hold",   {63'd0, des_req}, 64'd1);
            chk("key_stable", {8'd0, des_key},  {8'd0, k});
        end
        des_ack = 1'b1;
        des_ct  = (k == match_key) ? TGT : ~TGT;
        @(negedge clk); des_ack = 1'b0;
        chk("busy_done", {63'd0, busy},    64'd0);
        chk("req_done",  {63'd0, des_req}, 64'd0);
        en1 = 1'b1;
        if (up_with_en1) up = 1'b1;
        @(negedge clk); en1 = 1'b0; up = 1'b0;
        chk("found",     {63'd0, found},     {63'd0, ef});
        chk("exhausted", {63'd0, exhausted}, {63'd0, ex});
        chk("req_idle",  {63'd0, des_req},   64'd0);
    endtask

    initial begin
        // Reset state
        match_key = '1;
        do_reset();
        chk("rst_req",   {63'd0, des_req},   64'd0);
        chk("rst_busy",  {63'd0, busy},      64'd0);
        chk("rst_found", {63'd0, found},     64'd0);
        chk("rst_exh",   {63'd0, exhausted}, 64'd0);
        chk("rst_kv",    {63'd0, key_valid}, 64'd0);
        chk("rst_kout",  {8'd0, key_out},    64'd0);

        // Match at 0x13 in 0x10..0x1F; up+en1 together on the 2nd trial
        start_key = 56'h10; end_key = 56'h1F; match_key = 56'h13;
        trial(56'h10, 0, 0, 0, 0, 0);
        @(negedge clk); en2 = 1'b1;     // en2 without found: no effect
        @(negedge clk); en2 = 1'b0;
        chk("en2_nofound", {63'd0, key_valid}, 64'd0);
        trial(56'h11, 1, 0, 1, 0, 0);
        trial(56'h12, 0, 0, 0, 0, 0);   // key 0x12 proves the dropped up did not step
        trial(56'h13, 2, 0, 0, 1, 0);
        @(negedge clk); en2 = 1'b1;
        @(negedge clk); en2 = 1'b0;
        chk("kout_match", {8'd0, key_out},    64'h13);
        chk("kv_match",   {63'd0, key_valid}, 64'd1);
        pulse_up_refused("up_after_found");

        // No match in 0x10..0x12, ack delays 0/1/7, up during REQ ignored
        do_reset();
        start_key = 56'h10; end_key = 56'h12; match_key = 56'hFF;
        trial(56'h10, 0, 0, 0, 0, 0);
        trial(56'h11, 1, 1, 0, 0, 0);
        trial(56'h12, 7, 1, 0, 0, 1);
        pulse_up_refused("up_after_exh");
        chk("found_exh", {63'd0, found}, 64'd0);

        // Wrap through all-ones, match at 0
        do_reset();
        start_key = 56'hFF_FFFF_FFFF_FFFE; end_key = 56'h01; match_key = 56'h00;
        trial(56'hFF_FFFF_FFFF_FFFE, 0, 0, 0, 0, 0);
        trial(56'hFF_FFFF_FFFF_FFFF, 0, 0, 0, 0, 0);
        trial(56'h00, 0, 0, 0, 1, 0);
        @(negedge clk); en2 = 1'b1;
        @(negedge clk); en2 = 1'b0;
        chk("kout_wrap", {8'd0, key_out}, 64'h0);

        // start_key == end_key: single trial
        do_reset();
        start_key = 56'h20; end_key = 56'h20; match_key = 56'hFF;
        trial(56'h20, 0, 0, 0, 0, 1);

        // Reset mid-trial, then a stale matching ack
        do_reset();
        start_key = 56'h10; end_key = 56'h1F; match_key = 56'h10;
        @(negedge clk); up = 1'b1;
        @(negedge clk); up = 1'b0;
        @(negedge clk); reset = 1'b0;
        @(negedge clk);
        chk("rr_req",  {63'd0, des_req}, 64'd0);
        chk("rr_busy", {63'd0, busy},    64'd0);
        reset = 1'b1;
        des_ack = 1'b1; des_ct = TGT;
        @(negedge clk); des_ack = 1'b0;
        en1 = 1'b1;
        @(negedge clk); en1 = 1'b0;
        chk("rr_found", {63'd0, found},     64'd0);
        chk("rr_exh",   {63'd0, exhausted}, 64'd0);
        chk("rr_req2",  {63'd0, des_req},   64'd0);
        chk("rr_kv",    {63'd0, key_valid}, 64'd0);
        match_key = 56'hFF;
        trial(56'h10, 0, 0, 0, 0, 0);   // start_key reloaded after reset

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
